// File: rtl/max_score_tracker.sv
// Running maximum cell score over one alignment, fed one PE-array tile per valid cycle.
// Two-stage pipeline: in-tile reduction, then compare against the running maximum.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last result
// TRACK | accepting tiles until the one marked last_tile
// DRAIN | no new tiles; waiting for the last tile to leave stage 2
// DONE  | one-cycle done pulse, then back to IDLE
module max_score_tracker #(
  parameter int NUM_ROWS_PE   = 4,
  parameter int NUM_COLS_PE   = 4,
  parameter int SCORE_WIDTH   = 10,
  parameter int ROW_IDX_WIDTH = 10,
  parameter int COL_IDX_WIDTH = 10
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       tile_valid,
  input  logic                                       last_tile,
  input  logic [ROW_IDX_WIDTH-1:0]                   tile_row_base,
  input  logic [COL_IDX_WIDTH-1:0]                   tile_col_base,
  input  logic [NUM_ROWS_PE*NUM_COLS_PE*SCORE_WIDTH-1:0] scores_in,
  output logic [SCORE_WIDTH-1:0]                     max_score,
  output logic [ROW_IDX_WIDTH-1:0]                   max_row,
  output logic [COL_IDX_WIDTH-1:0]                   max_col,
  output logic                                       busy,
  output logic                                       done
);

  localparam int RI_W = (NUM_ROWS_PE > 1) ? $clog2(NUM_ROWS_PE) : 1;
  localparam int CJ_W = (NUM_COLS_PE > 1) ? $clog2(NUM_COLS_PE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                     accept;
  logic [SCORE_WIDTH-1:0]   red_score;
  logic [RI_W-1:0]          red_i;
  logic [CJ_W-1:0]          red_j;
  logic [ROW_IDX_WIDTH-1:0] red_row;
  logic [COL_IDX_WIDTH-1:0] red_col;

  logic                     s1_valid;
  logic                     s1_last;
  logic [SCORE_WIDTH-1:0]   s1_score;
  logic [ROW_IDX_WIDTH-1:0] s1_row;
  logic [COL_IDX_WIDTH-1:0] s1_col;
  logic                     s2_last;

  // A restart in the same cycle as a tile drops the tile.
  assign accept = (state == TRACK) && tile_valid && !start;

  // Strict compare in row-major scan keeps the first occurrence on ties.
  always_comb begin
    red_score = scores_in[SCORE_WIDTH-1:0];
    red_i     = '0;
    red_j     = '0;
    for (int i = 0; i < NUM_ROWS_PE; i++) begin
      for (int j = 0; j < NUM_COLS_PE; j++) begin
        if (scores_in[(i*NUM_COLS_PE + j)*SCORE_WIDTH +: SCORE_WIDTH] > red_score) begin
          red_score = scores_in[(i*NUM_COLS_PE + j)*SCORE_WIDTH +: SCORE_WIDTH];
          red_i     = RI_W'(i);
          red_j     = CJ_W'(j);
        end
      end
    end
  end

  // Index addition wraps modulo the index width.
  assign red_row = tile_row_base + ROW_IDX_WIDTH'(red_i);
  assign red_col = tile_col_base + COL_IDX_WIDTH'(red_j);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_score <= '0;
      s1_row   <= '0;
      s1_col   <= '0;
    end else if (start) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept && last_tile;
      if (accept) begin
        s1_score <= red_score;
        s1_row   <= red_row;
        s1_col   <= red_col;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_score <= '0;
      max_row   <= '0;
      max_col   <= '0;
      s2_last   <= 1'b0;
    end else if (start) begin
      max_score <= '0;
      max_row   <= '0;
      max_col   <= '0;
      s2_last   <= 1'b0;
    end else begin
      s2_last <= s1_valid && s1_last;
      if (s1_valid && (s1_score > max_score)) begin
        max_score <= s1_score;
        max_row   <= s1_row;
        max_col   <= s1_col;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = TRACK;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        TRACK:   if (accept && last_tile) state_nxt = DRAIN;
        DRAIN:   if (s2_last) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == TRACK) || (state == DRAIN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_max_score_tracker.sv
// Bench for max_score_tracker: directed scenarios plus random alignments,
// checked every cycle against a tile-event reference model.
module tb_max_score_tracker;

  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             tile_valid;
  logic             last_tile;
  logic [9:0]       tile_row_base;
  logic [9:0]       tile_col_base;
  logic [R*C*W-1:0] scores_in;
  logic [9:0]       max_score;
  logic [9:0]       max_row;
  logic [9:0]       max_col;
  logic             busy;
  logic             done;

  max_score_tracker dut (
    .clk(clk), .rst(rst), .start(start), .tile_valid(tile_valid),
    .last_tile(last_tile), .tile_row_base(tile_row_base),
    .tile_col_base(tile_col_base), .scores_in(scores_in),
    .max_score(max_score), .max_row(max_row), .max_col(max_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int at; int s; int r; int c;} ev_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   active;
  int   done_at;
  int   m_score, m_row, m_col;
  ev_t  ev_q[$];
  logic [9:0] tl [R][C];

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    active = 0; done_at = -1;
    m_score = 0; m_row = 0; m_col = 0;
    ev_q.delete();
  endtask

  // Sampled at the rising edge with the inputs the DUT sees.
  task automatic model_edge();
    int best, bi, bj;
    cyc++;
    if (start) begin
      active = 1; done_at = -1;
      m_score = 0; m_row = 0; m_col = 0;
      ev_q.delete();
    end else if (active != 0 && tile_valid) begin
      best = -1; bi = 0; bj = 0;
      for (int i = 0; i < R; i++)
        for (int j = 0; j < C; j++)
          if (int'(tl[i][j]) > best) begin best = int'(tl[i][j]); bi = i; bj = j; end
      ev_q.push_back('{at: cyc + 1, s: best,
                       r: (int'(tile_row_base) + bi) % 1024,
                       c: (int'(tile_col_base) + bj) % 1024});
      if (last_tile) begin active = 0; done_at = cyc + 2; end
    end
  endtask

  task automatic check_all();
    ev_t e;
    while (ev_q.size() > 0 && ev_q[0].at <= cyc) begin
      e = ev_q.pop_front();
      if (e.s > m_score) begin m_score = e.s; m_row = e.r; m_col = e.c; end
    end
    chk_val("max_score", 32'(max_score), 32'(m_score));
    chk_val("max_row",   32'(max_row),   32'(m_row));
    chk_val("max_col",   32'(max_col),   32'(m_col));
    chk_val("busy", 32'(busy), 32'((active != 0) || (done_at > cyc)));
    chk_val("done", 32'(done), 32'(done_at == cyc));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input logic st, input logic tv, input logic lt,
                       input int rb, input int cb);
    start = st; tile_valid = tv; last_tile = lt;
    tile_row_base = 10'(rb); tile_col_base = 10'(cb);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        scores_in[(i*C + j)*W +: W] = tl[i][j];
    tick();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0);
  endtask

  task automatic fill_peak(input int maxv, input int mi, input int mj);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        tl[i][j] = (maxv == 0) ? 10'd0 : 10'($urandom_range(0, maxv - 1));
    tl[mi][mj] = 10'(maxv);
  endtask

  task automatic fill_rand(input int hi);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++)
        tl[i][j] = 10'($urandom_range(0, hi));
  endtask

  initial begin
    int peaks[5];
    int n, hi;
    rst = 1'b1;
    fill_rand(0);
    start = 0; tile_valid = 0; last_tile = 0;
    tile_row_base = '0; tile_col_base = '0; scores_in = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_all();
    rst = 1'b0;
    idle(2);

    // single tile: 9 at (2,1), base (8,12) -> (10,13)
    drive(1, 0, 0, 0, 0);
    fill_peak(9, 2, 1);
    drive(0, 1, 1, 8, 12);
    idle(5);

    // in-tile tie, then a later equal tile
    drive(1, 0, 0, 0, 0);
    fill_peak(15, 1, 3); tl[2][0] = 10'd15;
    drive(0, 1, 0, 100, 200);
    fill_peak(15, 0, 0);
    drive(0, 1, 1, 300, 400);
    idle(5);

    // streaming 3,20,7,21,21
    peaks = '{3, 20, 7, 21, 21};
    drive(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      fill_peak(peaks[k], k % R, (k + 1) % C);
      drive(0, 1, k == 4, 16 * k, 4 * k);
    end
    idle(5);

    // row index wrap: base 1022 + i=3 -> 1
    drive(1, 0, 0, 0, 0);
    fill_peak(50, 3, 2);
    drive(0, 1, 1, 1022, 1020);
    idle(4);
    // tiles while IDLE are ignored
    fill_peak(900, 1, 1);
    drive(0, 1, 0, 5, 5);
    drive(0, 1, 1, 5, 5);
    idle(2);

    // all-zero alignment
    drive(1, 0, 0, 0, 0);
    fill_peak(0, 0, 0);
    drive(0, 1, 0, 33, 44);
    drive(0, 1, 1, 55, 66);
    idle(5);

    // asynchronous reset mid-run with max_score 37
    drive(1, 0, 0, 0, 0);
    fill_peak(37, 1, 2);
    drive(0, 1, 0, 7, 9);
    idle(3);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    check_all();
    rst = 1'b0;
    idle(3);

    // restart during DRAIN
    drive(1, 0, 0, 0, 0);
    fill_peak(60, 0, 1);
    drive(0, 1, 1, 10, 10);
    drive(1, 0, 0, 0, 0);
    fill_peak(12, 3, 3);
    drive(0, 1, 0, 20, 30);
    fill_peak(18, 2, 2);
    drive(0, 1, 1, 40, 50);
    idle(5);

    // random alignments
    for (int a = 0; a < 25; a++) begin
      drive(1, 0, 0, 0, 0);
      n  = $urandom_range(1, 10);
      hi = ($urandom_range(0, 1) != 0) ? 7 : 1023;
      for (int k = 0; k < n; k++) begin
        fill_rand(hi);
        if ($urandom_range(0, 19) == 0)
          drive(1, 1, 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
        else
          drive(0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 1023), $urandom_range(0, 1023));
      end
      fill_rand(hi);
      drive(0, 1, 1, $urandom_range(0, 1023), $urandom_range(0, 1023));
      fill_rand(hi);
      for (int k = 0; k < 5; k++)
        drive(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1023), 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/max_score_tracker.md
Name: max_score_tracker

Overview:
- Sits directly downstream of the PE-array processing unit.
- Each valid cycle it consumes the full NUM_ROWS_PE x NUM_COLS_PE tile of cell scores.
- It tracks the running maximum cell score over one alignment, with the global matrix coordinates of that cell.
- It reports the final maximum and the traceback start position to the controller when the last tile drains.

Parameters:
- NUM_ROWS_PE, 4, PE rows per tile.
- NUM_COLS_PE, 4, PE columns per tile.
- SCORE_WIDTH, 10, unsigned cell score width.
- ROW_IDX_WIDTH, 10, global database-row index width.
- COL_IDX_WIDTH, 10, global query-column index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that clears the tracker and begins a new alignment.
- tile_valid  input  1  scores_in/tile bases are valid this cycle.
- last_tile  input  1  qualifies tile_valid; marks the final tile of the alignment.
- tile_row_base  input  ROW_IDX_WIDTH  global row of PE row 0.
- tile_col_base  input  COL_IDX_WIDTH  global column of PE column 0.
- scores_in  input  NUM_ROWS_PE*NUM_COLS_PE*SCORE_WIDTH  processing-unit scores_out, packed [row][col].
- max_score  output  SCORE_WIDTH  running/final maximum score.
- max_row  output  ROW_IDX_WIDTH  global row of max_score.
- max_col  output  COL_IDX_WIDTH  global column of max_score.
- busy  output  1  high in TRACK and DRAIN states.
- done  output  1  one-cycle pulse; outputs are final.

Behaviour:
- Reset (async, rst=1): state IDLE; max_score=0, max_row=0, max_col=0, busy=0, done=0; all pipeline valids cleared. Reset mid-operation discards all in-flight tiles.
- FSM states:
  - IDLE: start -> TRACK; clears max regs and pipeline.
  - TRACK: accepts tile_valid. tile_valid & last_tile -> DRAIN.
  - DRAIN: no input accepted. After the last tile reaches stage 2 (2 cycles after acceptance) -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - start in any state: restarts (clear regs/pipeline, go to TRACK) and takes priority over every other transition. done is not asserted for the aborted alignment.
- tile_valid in IDLE, DRAIN or DONE is ignored. last_tile without tile_valid is ignored.
- Pipeline stage 1 (registered on acceptance):
  - In-tile reduction to the tile max value plus local (i,j).
  - Tie rule: the first in row-major order wins (lowest i, then lowest j).
  - Global coordinates are computed as tile_row_base+i and tile_col_base+j, truncated modulo the index width (wrap-around, no saturation).
- Pipeline stage 2:
  - If the stage-1 tile max is strictly greater than max_score, update max_score, max_row and max_col.
  - Equal values do not update, so the earliest tile in time wins ties.
- Latency: a tile accepted at cycle t is reflected on the max_* outputs at t+2. done is asserted at t+3 for the last tile, and outputs hold stable from t+2.
- Back-to-back tiles are accepted every cycle; there is no backpressure.
- All-zero alignment: max_score=0, max_row=0, max_col=0 at done.
- max_* hold their values after done until the next start or rst.
- busy=1 in TRACK and DRAIN, and 0 in IDLE and DONE.

Test Plan:
- Reset mid-run: assert rst asynchronously during TRACK with max_score=37 -> all outputs 0 immediately, state IDLE, no done pulse.
- Single tile: start; tile with score 9 at (i=2,j=1), all other cells <9, base (8,12), last_tile=1 -> at t+2 max_score=9, max_row=10, max_col=13; done pulses at t+3; busy falls with done.
- Tie handling:
  - In-tile: 15 at (1,3) and at (2,0) -> position (1,3) chosen.
  - Across tiles: a later tile also reaching 15 leaves coordinates unchanged.
- Streaming: 5 back-to-back tiles with maxima 3, 20, 7, 21, 21 -> final max_score=21 with the coordinates of the 4th tile; max_score sequence at t+2.. is 3, 20, 20, 21, 21; exactly one done.
- Index wrap and ignored inputs:
  - tile_row_base=1022 with max at i=3 (ROW_IDX_WIDTH=10) -> max_row=1.
  - tile_valid while IDLE -> no change to max_*.
- Restart: start asserted during DRAIN -> no done for the aborted run, max regs cleared, new alignment tracked correctly.
